// File: rtl/localbp_update_queue.sv
// localbp_update_queue: queues resolved local-history updates for the BHT write port
// and forwards the newest pending LHR to the fetch-side lookup.
`default_nettype none

module localbp_update_queue #(
    parameter int XLEN  = 64,
    parameter int m     = 6,
    parameter int k     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     EnqValid,
    input  logic [m-1:0]             EnqIndex,
    input  logic                     EnqTaken,
    input  logic [k-1:0]             EnqLHR,
    output logic                     EnqReady,
    output logic                     Dropped,
    output logic                     WrEn,
    output logic [m-1:0]             WrIndex,
    output logic [k-1:0]             WrLHR,
    input  logic                     WrGrant,
    input  logic [m-1:0]             LookupIndex,
    output logic                     LookupHit,
    output logic [k-1:0]             LookupLHR,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    // XLEN is carried only so all predictor blocks share one parameter list.
    if (XLEN > 0) begin : g_xlen_present
    end

    logic [DEPTH-1:0] valid_q;
    logic [m-1:0]     idx_q [DEPTH];
    logic [k-1:0]     lhr_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             deq;
    logic             fire;
    logic [k-1:0]     base;
    logic [k-1:0]     new_lhr;
    logic [PTR_W-1:0] enq_pos;
    logic [PTR_W-1:0] lk_pos;

    assign WrEn     = (count_q != '0);
    assign WrIndex  = idx_q[head_q];
    assign WrLHR    = lhr_q[head_q];
    assign deq      = WrEn & WrGrant;
    assign EnqReady = (count_q != C_FULL) | deq;
    assign Dropped  = EnqValid & ~EnqReady;
    assign fire     = EnqValid & EnqReady;
    assign Count    = count_q;
    assign new_lhr  = {EnqTaken, base[k-1:1]};

    // Walk oldest to newest so the last match is the newest pending history.
    always_comb begin
        base    = EnqLHR;
        enq_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            enq_pos = head_q + PTR_W'(i);
            if (valid_q[enq_pos] && (idx_q[enq_pos] == EnqIndex)) begin
                base = lhr_q[enq_pos];
            end
        end
    end

    always_comb begin
        LookupHit = 1'b0;
        LookupLHR = '0;
        lk_pos    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_pos = head_q + PTR_W'(i);
            if (valid_q[lk_pos] && (idx_q[lk_pos] == LookupIndex)) begin
                LookupHit = 1'b1;
                LookupLHR = lhr_q[lk_pos];
            end
        end
    end

    always_comb begin
        head_d  = deq  ? head_q + 1'b1 : head_q;
        tail_d  = fire ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (fire && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!fire && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    // When full, head and tail alias; the enqueue write must win over the invalidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                lhr_q[i] <= '0;
            end
        end else begin
            if (deq) begin
                valid_q[head_q] <= 1'b0;
            end
            if (fire) begin
                valid_q[tail_q] <= 1'b1;
                idx_q[tail_q]   <= EnqIndex;
                lhr_q[tail_q]   <= new_lhr;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_localbp_update_queue.sv
// tb_localbp_update_queue: scoreboard bench; expected entries are queued on enqueue
// and popped when the DUT drains them to the BHT write port.
`default_nettype none

module tb_localbp_update_queue;

    localparam int M = 6;
    localparam int K = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         EnqValid;
    logic [M-1:0] EnqIndex;
    logic         EnqTaken;
    logic [K-1:0] EnqLHR;
    logic         EnqReady;
    logic         Dropped;
    logic         WrEn;
    logic [M-1:0] WrIndex;
    logic [K-1:0] WrLHR;
    logic         WrGrant;
    logic [M-1:0] LookupIndex;
    logic         LookupHit;
    logic [K-1:0] LookupLHR;
    logic [2:0]   Count;

    localbp_update_queue #(.XLEN(64), .m(M), .k(K), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .EnqValid(EnqValid), .EnqIndex(EnqIndex), .EnqTaken(EnqTaken), .EnqLHR(EnqLHR),
        .EnqReady(EnqReady), .Dropped(Dropped),
        .WrEn(WrEn), .WrIndex(WrIndex), .WrLHR(WrLHR), .WrGrant(WrGrant),
        .LookupIndex(LookupIndex), .LookupHit(LookupHit), .LookupLHR(LookupLHR),
        .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [M-1:0] idx;
        logic [K-1:0] lhr;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {hit, lhr} of the newest pending scoreboard entry for an index.
    function automatic logic [K:0] model_find(input logic [M-1:0] ix);
        logic [K:0] r;
        r = '0;
        foreach (sb[i]) if (sb[i].idx == ix) r = {1'b1, sb[i].lhr};
        return r;
    endfunction

    task automatic cycle();
        logic [K:0]   lk, bs;
        logic         deq, rdy, fire;
        logic [K-1:0] base, nl;
        ent_t         e;
        @(negedge clk);
        deq  = (sb.size() != 0) && WrGrant;
        rdy  = (sb.size() != D) || deq;
        fire = EnqValid && rdy;
        chk("count",   32'(Count),    32'(sb.size()));
        chk("wren",    32'(WrEn),     32'(sb.size() != 0));
        chk("ready",   32'(EnqReady), 32'(rdy));
        chk("dropped", 32'(Dropped),  32'(EnqValid && !rdy));
        lk = model_find(LookupIndex);
        chk("lk_hit",  32'(LookupHit), 32'(lk[K]));
        chk("lk_lhr",  32'(LookupLHR), 32'(lk[K-1:0]));
        bs   = model_find(EnqIndex);
        base = bs[K] ? bs[K-1:0] : EnqLHR;
        nl   = {EnqTaken, base[K-1:1]};
        if (deq) begin
            e = sb.pop_front();
            chk("wr_idx", 32'(WrIndex), 32'(e.idx));
            chk("wr_lhr", 32'(WrLHR),   32'(e.lhr));
        end else if (sb.size() != 0) begin
            chk("wr_hold", 32'(WrLHR), 32'(sb[0].lhr));
        end
        if (fire) sb.push_back({EnqIndex, nl});
        if (reset) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [M-1:0] ix, input logic t, input logic [K-1:0] l);
        EnqValid = 1'b1;
        EnqIndex = ix;
        EnqTaken = t;
        EnqLHR   = l;
        cycle();
        EnqValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; EnqValid = 1'b0; EnqIndex = '0; EnqTaken = 1'b0; EnqLHR = '0;
        WrGrant = 1'b0; LookupIndex = '0;
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("idle_wren",  32'(WrEn),      32'd0);
        chk("idle_hit",   32'(LookupHit), 32'd0);
        chk("idle_ready", 32'(EnqReady),  32'd1);
        chk("idle_count", 32'(Count),     32'd0);

        // Single enqueue, port not granted.
        enq(6'd5, 1'b1, 10'h001);
        LookupIndex = 6'd5; #1;
        chk("first_wren", 32'(WrEn),      32'd1);
        chk("first_widx", 32'(WrIndex),   32'd5);
        chk("first_wlhr", 32'(WrLHR),     32'h200);
        chk("first_hit",  32'(LookupHit), 32'd1);
        chk("first_llhr", 32'(LookupLHR), 32'h200);
        LookupIndex = 6'd6; #1;
        chk("miss_hit",   32'(LookupHit), 32'd0);
        chk("miss_llhr",  32'(LookupLHR), 32'd0);

        // Chaining through a pending entry for the same index.
        do_reset();
        enq(6'd5, 1'b1, 10'h000);
        enq(6'd5, 1'b0, 10'h000);
        LookupIndex = 6'd5; #1;
        chk("chain_llhr", 32'(LookupLHR), 32'h100);
        chk("chain_head", 32'(WrLHR),     32'h200);
        cycle();

        // Fill, drop, then accept while full with a simultaneous dequeue.
        do_reset();
        for (int i = 0; i < D; i++) enq(6'(10 + i), 1'(i), 10'(i));
        #1;
        chk("full_count", 32'(Count),    32'd4);
        chk("full_ready", 32'(EnqReady), 32'd0);
        EnqValid = 1'b1; EnqIndex = 6'd20; EnqTaken = 1'b1; EnqLHR = 10'h3ff; #1;
        chk("full_drop",  32'(Dropped),  32'd1);
        cycle();
        chk("drop_count", 32'(Count),    32'd4);
        WrGrant = 1'b1; EnqIndex = 6'd21; #1;
        chk("full_acc_ready", 32'(EnqReady), 32'd1);
        cycle();
        EnqValid = 1'b0; WrGrant = 1'b0; #1;
        chk("full_acc_count", 32'(Count),   32'd4);
        chk("full_acc_head",  32'(WrIndex), 32'd11);

        // Drain three entries in order.
        do_reset();
        enq(6'd1, 1'b1, 10'h011);
        enq(6'd2, 1'b0, 10'h022);
        enq(6'd3, 1'b1, 10'h033);
        WrGrant = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("drain_wren",  32'(WrEn),  32'd0);
        chk("drain_count", 32'(Count), 32'd0);
        WrGrant = 1'b0;

        // Reset with a concurrent enqueue mid-operation.
        enq(6'd7, 1'b1, 10'h0);
        enq(6'd8, 1'b1, 10'h0);
        enq(6'd9, 1'b1, 10'h0);
        EnqValid = 1'b1; EnqIndex = 6'd7; LookupIndex = 6'd7;
        do_reset();
        EnqValid = 1'b0; #1;
        chk("rst_count", 32'(Count),     32'd0);
        chk("rst_wren",  32'(WrEn),      32'd0);
        chk("rst_hit",   32'(LookupHit), 32'd0);

        // Random traffic over a small index range to exercise chaining and aliasing.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            EnqValid    = 1'($urandom_range(0, 1));
            EnqIndex    = 6'($urandom_range(0, 3));
            EnqTaken    = 1'($urandom_range(0, 1));
            EnqLHR      = 10'($urandom);
            WrGrant     = ($urandom_range(0, 2) != 0);
            LookupIndex = 6'($urandom_range(0, 3));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
